// File: rtl/gb_timer.sv
// gb_timer: Game Boy DIV/TIMA/TMA/TAC timer unit.
// Owns the 16-bit system counter, the four timer registers at FF04-FF07 and
// the TIMA overflow -> delayed reload -> interrupt sequence.
module gb_timer (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       wr_en,
    input  logic [1:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] DIV,
    output logic [7:0] TIMA,
    output logic [7:0] TMA,
    output logic [7:0] TAC,
    output logic       timer_irq
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        RELOAD = 2'd2
    } state_t;

    localparam logic [1:0] ADDR_DIV  = 2'd0;
    localparam logic [1:0] ADDR_TIMA = 2'd1;
    localparam logic [1:0] ADDR_TMA  = 2'd2;
    localparam logic [1:0] ADDR_TAC  = 2'd3;

    state_t      state, state_next;
    logic [15:0] sys_cnt, sys_cnt_next;
    logic [2:0]  tac, tac_next;
    logic [7:0]  tma, tma_next;
    logic [7:0]  tima, tima_next;
    logic [1:0]  dly, dly_next;
    logic        irq_next;

    logic wr_div, wr_tima, wr_tma, wr_tac;
    logic inc_event;

    // Timer input: the enable bit ANDed with the system-counter bit chosen by
    // the clock select. Its falling edge is what advances TIMA.
    function automatic logic tick(input logic [2:0] t, input logic [15:0] c);
        logic b;
        unique case (t[1:0])
            2'd0: b = c[9];
            2'd1: b = c[3];
            2'd2: b = c[5];
            2'd3: b = c[7];
        endcase
        return t[2] & b;
    endfunction

    assign wr_div  = wr_en && (addr == ADDR_DIV);
    assign wr_tima = wr_en && (addr == ADDR_TIMA);
    assign wr_tma  = wr_en && (addr == ADDR_TMA);
    assign wr_tac  = wr_en && (addr == ADDR_TAC);

    // Next values of the plain registers and the increment event; the event
    // compares the tick before and after this edge's DIV/TAC writes, so those
    // writes can produce the hardware's glitch increment.
    always_comb begin
        sys_cnt_next = wr_div ? 16'h0000 : sys_cnt + 16'd1;
        tac_next     = wr_tac ? wdata[2:0] : tac;
        tma_next     = wr_tma ? wdata : tma;
        inc_event    = tick(tac, sys_cnt) & ~tick(tac_next, sys_cnt_next);
    end

    // Overflow sequencing: TIMA update, delay count, reload and interrupt.
    always_comb begin
        // NOTE: every output of a combinational block is given a default
        // before any branch; a path that leaves one unassigned infers a latch.
        state_next = state;
        tima_next  = tima;
        dly_next   = dly;
        irq_next   = 1'b0;
        unique case (state)
            IDLE: begin
                if (wr_tima) begin
                    // A CPU write beats a simultaneous increment.
                    tima_next = wdata;
                end else if (inc_event) begin
                    if (tima == 8'hFF) begin
                        tima_next  = 8'h00;
                        dly_next   = 2'd0;
                        state_next = DELAY;
                    end else begin
                        tima_next = tima + 8'd1;
                    end
                end
            end
            DELAY: begin
                if (wr_tima) begin
                    // Writing TIMA during the delay cancels the pending reload.
                    tima_next  = wdata;
                    state_next = IDLE;
                end else begin
                    dly_next = dly + 2'd1;
                    if (dly == 2'd2) begin
                        state_next = RELOAD;
                    end
                end
            end
            RELOAD: begin
                // TIMA writes are ignored here; a TMA write lands in TIMA too.
                tima_next  = wr_tma ? wdata : tma;
                irq_next   = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and register storage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            sys_cnt   <= 16'h0000;
            tac       <= 3'b000;
            tma       <= 8'h00;
            tima      <= 8'h00;
            dly       <= 2'd0;
            timer_irq <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the values from before this clock edge.
            state     <= state_next;
            sys_cnt   <= sys_cnt_next;
            tac       <= tac_next;
            tma       <= tma_next;
            tima      <= tima_next;
            dly       <= dly_next;
            timer_irq <= irq_next;
        end
    end

    assign DIV  = sys_cnt[15:8];
    assign TIMA = tima;
    assign TMA  = tma;
    assign TAC  = {5'b11111, tac};

endmodule

// File: tb/tb_gb_timer.sv
// tb_gb_timer: directed and randomized checks of gb_timer against an
// edge-counting reference model.
module tb_gb_timer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [1:0] addr = 2'd0;
    logic [7:0] wdata = 8'h00;
    logic [7:0] DIV, TIMA, TMA, TAC;
    logic       timer_irq;

    int  n_checks = 0;
    int  n_pass   = 0;
    bit  chk_en   = 1'b0;

    gb_timer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en     (wr_en),
        .addr      (addr),
        .wdata     (wdata),
        .DIV       (DIV),
        .TIMA      (TIMA),
        .TMA       (TMA),
        .TAC       (TAC),
        .timer_irq (timer_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Time-stamped view: remember the edge number at which TIMA overflowed;
    // edges 1..3 later are the cancellable window, edge 4 later is the reload.
    logic [15:0] m_cnt = 16'h0000;
    logic [2:0]  m_tac = 3'b000;
    logic [7:0]  m_tma = 8'h00;
    logic [7:0]  m_tima = 8'h00;
    logic        m_irq = 1'b0;
    bit          m_pend = 1'b0;
    int unsigned m_edge = 0;
    int unsigned m_ovf_edge = 0;

    function automatic bit s_of(input logic [2:0] t, input logic [15:0] c);
        int idx [4] = '{9, 3, 5, 7};
        return t[2] && c[idx[t[1:0]]];
    endfunction

    always @(posedge clk or negedge reset_n) begin
        logic [15:0] n_cnt;
        logic [2:0]  n_tac;
        logic [7:0]  n_tma;
        bit          inc, wtima;
        int unsigned age;
        if (!reset_n) begin
            m_cnt = 16'h0000; m_tac = 3'b000; m_tma = 8'h00; m_tima = 8'h00;
            m_irq = 1'b0; m_pend = 1'b0; m_edge = 0; m_ovf_edge = 0;
        end else begin
            n_cnt = (wr_en && addr == 2'd0) ? 16'h0000 : m_cnt + 16'd1;
            n_tac = (wr_en && addr == 2'd3) ? wdata[2:0] : m_tac;
            n_tma = (wr_en && addr == 2'd2) ? wdata : m_tma;
            wtima = wr_en && addr == 2'd1;
            inc   = s_of(m_tac, m_cnt) && !s_of(n_tac, n_cnt);
            m_edge++;
            age   = m_edge - m_ovf_edge;
            m_irq = 1'b0;
            if (m_pend && age < 4) begin
                if (wtima) begin
                    m_tima = wdata;
                    m_pend = 1'b0;
                end
            end else if (m_pend) begin
                m_tima = n_tma;
                m_irq  = 1'b1;
                m_pend = 1'b0;
            end else if (wtima) begin
                m_tima = wdata;
            end else if (inc) begin
                if (m_tima == 8'hFF) begin
                    m_tima     = 8'h00;
                    m_pend     = 1'b1;
                    m_ovf_edge = m_edge;
                end else begin
                    m_tima = m_tima + 8'd1;
                end
            end
            m_cnt = n_cnt;
            m_tac = n_tac;
            m_tma = n_tma;
        end
    end

    // Compare DUT outputs against the model on every falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("div",  {8'h00, DIV},  {8'h00, m_cnt[15:8]});
            check("tima", {8'h00, TIMA}, {8'h00, m_tima});
            check("tma",  {8'h00, TMA},  {8'h00, m_tma});
            check("tac",  {8'h00, TAC},  {8'h00, 5'b11111, m_tac});
            check("irq",  {15'h0, timer_irq}, {15'h0, m_irq});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic write_reg(input logic [1:0] a, input logic [7:0] d);
        wr_en = 1'b1;
        addr  = a;
        wdata = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic idle(input int n);
        wr_en = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Leaves the bench at the falling edge just after E0 (TIMA FF -> 00).
    task automatic arm_overflow();
        bit ok;
        idle(8);
        write_reg(2'd3, 8'h00);
        write_reg(2'd2, 8'hAB);
        write_reg(2'd1, 8'hFF);
        write_reg(2'd3, 8'h05);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (TIMA == 8'h00) begin
                ok = 1'b1;
                break;
            end
        end
        check("arm_overflow_timeout", {15'h0, ok}, 16'h0001);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("rst_div",  {8'h00, DIV},  16'h0000);
        check("rst_tima", {8'h00, TIMA}, 16'h0000);
        check("rst_tma",  {8'h00, TMA},  16'h0000);
        check("rst_tac",  {8'h00, TAC},  16'h00F8);
        check("rst_irq",  {15'h0, timer_irq}, 16'h0000);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        bit         irq_seen;
        logic [7:0] t0;
        int         r;
        logic [1:0] a;
        logic [7:0] d;

        // 1. reset values, DIV after 256 clocks
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("t1_div",  {8'h00, DIV},  16'h0000);
        check("t1_tima", {8'h00, TIMA}, 16'h0000);
        check("t1_tma",  {8'h00, TMA},  16'h0000);
        check("t1_tac",  {8'h00, TAC},  16'h00F8);
        check("t1_irq",  {15'h0, timer_irq}, 16'h0000);
        reset_n = 1'b1;
        idle(255);
        check("t1_div_255", {8'h00, DIV}, 16'h0000);
        idle(1);
        check("t1_div_256", {8'h00, DIV}, 16'h0001);

        // 2. 16-clock rate for 160 clocks
        write_reg(2'd3, 8'h05);
        check("t2_tac_fd", {8'h00, TAC}, 16'h00FD);
        idle(160);
        check("t2_tima_range", {15'h0, (TIMA >= 8'h09 && TIMA <= 8'h0B)}, 16'h0001);
        write_reg(2'd3, 8'h01);
        check("t2_tac_f9", {8'h00, TAC}, 16'h00F9);

        // 3. overflow timeline
        arm_overflow();
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check("t3_tima_delay", {8'h00, TIMA}, 16'h0000);
            check("t3_irq_delay",  {15'h0, timer_irq}, 16'h0000);
        end
        @(negedge clk);
        check("t3_tima_reload", {8'h00, TIMA}, 16'h00AB);
        check("t3_irq_reload",  {15'h0, timer_irq}, 16'h0001);
        @(negedge clk);
        check("t3_irq_after",  {15'h0, timer_irq}, 16'h0000);
        check("t3_tima_after", {8'h00, TIMA}, 16'h00AB);

        // 4a. TIMA write at E2 cancels the overflow
        arm_overflow();
        idle(1);
        write_reg(2'd1, 8'h42);
        check("t4_tima_cancel", {8'h00, TIMA}, 16'h0042);
        irq_seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            irq_seen |= timer_irq;
        end
        check("t4_no_irq", {15'h0, irq_seen}, 16'h0000);
        check("t4_tima_hold", {8'h00, TIMA}, 16'h0042);

        // 4b. TIMA write at E4 is ignored
        arm_overflow();
        idle(3);
        write_reg(2'd1, 8'h42);
        check("t4_tima_ignored", {8'h00, TIMA}, 16'h00AB);
        check("t4_irq_fires",    {15'h0, timer_irq}, 16'h0001);

        // 5. DIV write with the selected bit high gives a glitch increment
        write_reg(2'd1, 8'h10);
        write_reg(2'd0, 8'h00);
        idle(8);
        t0 = TIMA;
        write_reg(2'd0, 8'h5A);
        check("t5_div_clear", {8'h00, DIV}, 16'h0000);
        check("t5_glitch_inc", {8'h00, TIMA}, {8'h00, t0 + 8'd1});

        // 6. reset in the middle of the delay window
        arm_overflow();
        idle(1);
        reset_pulse();
        irq_seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            irq_seen |= timer_irq;
        end
        check("t6_no_irq", {15'h0, irq_seen}, 16'h0000);

        // Randomized traffic checked by the model on every cycle.
        write_reg(2'd3, 8'h05);
        for (int i = 0; i < 4000; i++) begin
            if (i == 1500 || i == 3000) begin
                reset_pulse();
            end
            r = $urandom_range(0, 99);
            if (r < 15) begin
                a = 2'($urandom_range(0, 3));
                d = 8'($urandom);
                if (a == 2'd3) begin
                    d[2] = ($urandom_range(0, 3) != 0);
                    if ($urandom_range(0, 1) == 1) d[1:0] = 2'b01;
                end
                if (a == 2'd1 && $urandom_range(0, 1) == 1) begin
                    d = 8'hFC + 8'($urandom_range(0, 3));
                end
                wr_en = 1'b1;
                addr  = a;
                wdata = d;
            end else begin
                wr_en = 1'b0;
            end
            @(negedge clk);
        end
        wr_en = 1'b0;
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
